// File: rtl/speed_level_ctrl.sv
// speed_level_ctrl: speed/level controller for a stacking game.
//
// A game is started (or restarted) by start. While running, every rising edge
// of stack_ok counts one successful stack: the level goes up and the step
// period shortens (halving in MODE 0, subtracting STEP in MODE 1, never below
// MIN_TIME). A stack_miss ends the game; reaching MAX_LEVEL ends it as a win.
// A tick pulse marks every step_time cycles while running.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      load init_time and begin/restart a game (highest priority)
//   init_time  starting step period in cycles
//   stack_ok   level input; each 0->1 transition is one successful stack
//   stack_miss failed stack; ends the game while running
//   step_time  current step period in cycles
//   level      successful stacks this game
//   tick       one-cycle pulse every step_time cycles while running
//   running    game in progress
//   game_over  game ended
//   won        game ended by reaching MAX_LEVEL
//   at_floor   step_time has reached MIN_TIME (combinational)
`timescale 1ns/1ps
module speed_level_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_LEVEL = 15,
  parameter int unsigned MODE      = 0,
  parameter int unsigned STEP      = 4,
  parameter int unsigned MIN_TIME  = 1,
  localparam int unsigned LW       = $clog2(MAX_LEVEL + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] init_time,
  input  logic             stack_ok,
  input  logic             stack_miss,
  output logic [WIDTH-1:0] step_time,
  output logic [LW-1:0]    level,
  output logic             tick,
  output logic             running,
  output logic             game_over,
  output logic             won,
  output logic             at_floor
);

  localparam logic [WIDTH-1:0] MinTime   = WIDTH'(MIN_TIME);
  localparam logic [WIDTH-1:0] StepDec   = WIDTH'(STEP);
  // Wider than step_time so STEP + MIN_TIME cannot wrap.
  localparam logic [WIDTH:0]   StepFloor = (WIDTH + 1)'(STEP + MIN_TIME);
  localparam logic [LW-1:0]    MaxLevel  = LW'(MAX_LEVEL);

  typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ok_q;
  logic             tick_q, tick_d;
  logic             won_q, won_d;
  logic             running_q, game_over_q;

  logic             ok_rise;
  logic [WIDTH-1:0] start_time;
  logic [WIDTH-1:0] step_half;
  logic [WIDTH-1:0] next_step;

  assign ok_rise    = stack_ok & ~ok_q;
  assign start_time = (init_time < MinTime) ? MinTime : init_time;
  assign step_half  = step_q >> 1;

  always_comb begin
    next_step = MinTime;
    if (MODE == 0) begin
      next_step = (step_half < MinTime) ? MinTime : step_half;
    end else if ({1'b0, step_q} >= StepFloor) begin
      next_step = step_q - StepDec;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    won_d   = won_q;
    tick_d  = 1'b0;
    if (start) begin
      state_d = StRun;
      level_d = '0;
      won_d   = 1'b0;
      step_d  = start_time;
      cnt_d   = start_time - WIDTH'(1);
    end else if (state_q == StRun) begin
      if (stack_miss) begin
        state_d = StOver;
      end else if (ok_rise) begin
        // Level change restarts the period with the new step; no tick here.
        level_d = level_q + LW'(1);
        step_d  = next_step;
        cnt_d   = next_step - WIDTH'(1);
        if (level_d == MaxLevel) begin
          state_d = StOver;
          won_d   = 1'b1;
        end
      end else if (cnt_q == '0) begin
        tick_d = 1'b1;
        cnt_d  = step_q - WIDTH'(1);
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      step_q      <= '0;
      cnt_q       <= '0;
      level_q     <= '0;
      ok_q        <= 1'b0;
      tick_q      <= 1'b0;
      won_q       <= 1'b0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      ok_q        <= stack_ok;
      tick_q      <= tick_d;
      won_q       <= won_d;
      running_q   <= (state_d == StRun);
      game_over_q <= (state_d == StOver);
    end
  end

  assign step_time = step_q;
  assign level     = level_q;
  assign tick      = tick_q;
  assign running   = running_q;
  assign game_over = game_over_q;
  assign won       = won_q;
  assign at_floor  = (step_q == MinTime);

endmodule

// File: doc/speed_level_ctrl.md
SPEED_LEVEL_CTRL -- requirements
Module: speed_level_ctrl

Interface
REQ-001 Parameter WIDTH, 8, bit width of all time values.
REQ-002 Parameter MAX_LEVEL, 15, winning level; LW = $clog2(MAX_LEVEL+1).
REQ-003 Parameter MODE, 0, speed-up rule: 0 = halve per level, 1 = subtract STEP per level.
REQ-004 Parameter STEP, 4, decrement used in MODE 1.
REQ-005 Parameter MIN_TIME, 1, floor for step_time; legal range 1..2^WIDTH-1.
REQ-006 clk  input  1  rising-edge clock; the block SHALL have this single clock.
REQ-007 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-008 start  input  1  load init_time and begin or restart a game.
REQ-009 init_time  input  WIDTH  starting step period in cycles.
REQ-010 stack_ok  input  1  level signal; each 0->1 transition is one successful stack.
REQ-011 stack_miss  input  1  failed stack; any cycle high ends the game.
REQ-012 step_time  output  WIDTH  current step period in cycles.
REQ-013 level  output  LW  successful stacks this game.
REQ-014 tick  output  1  one-cycle pulse once per step_time cycles while running.
REQ-015 running  output  1  high in RUN.
REQ-016 game_over  output  1  high in OVER.
REQ-017 won  output  1  high in OVER when level reached MAX_LEVEL.
REQ-018 at_floor  output  1  step_time == MIN_TIME.

Function
REQ-019 The FSM SHALL have three states: IDLE, RUN and OVER; all outputs except at_floor SHALL be registered.
REQ-020 The block SHALL register stack_ok as ok_q in every state; an edge SHALL be stack_ok=1 with ok_q=0.
REQ-021 start in any state SHALL set the next state to RUN, level=0, won=0, and step_time=max(init_time, MIN_TIME), and SHALL load tick counter=step_time-1; start SHALL take priority over all other inputs.
REQ-022 In RUN, stack_miss=1 SHALL enter OVER with won=0 and level/step_time held; stack_miss SHALL take priority over a coincident edge.
REQ-023 In RUN, an edge without a miss SHALL set level=level+1, and both it and step_time SHALL become visible on the clock after the sampling edge (1-cycle latency).
REQ-024 Next step_time in MODE 0 SHALL be max(step_time>>1, MIN_TIME).
REQ-025 Next step_time in MODE 1 SHALL be step_time-STEP when step_time >= STEP+MIN_TIME, else MIN_TIME; no underflow or wrap.
REQ-026 At floor, edges SHALL still increment level with step_time unchanged.
REQ-027 An edge that makes level equal MAX_LEVEL SHALL enter OVER with won=1; level SHALL never exceed MAX_LEVEL.
REQ-028 Tick counter in RUN SHALL count down; at 0 it SHALL assert tick for one cycle and reload step_time-1, giving period = step_time cycles (every cycle when step_time=1).
REQ-029 On a level change the counter SHALL reload new step_time-1, and no tick SHALL occur that cycle.
REQ-030 In IDLE and OVER, tick SHALL be 0, the counter SHALL hold, and edges SHALL be ignored.
REQ-031 If stack_ok is already high at start, no edge SHALL be counted until it falls and rises again.

Reset
REQ-032 When rst_n=0, the block SHALL immediately set state=IDLE, step_time=0, level=0, counter=0, ok_q=0, tick=0, running=0, game_over=0 and won=0 (at_floor=0), including mid-RUN.
REQ-033 After rst_n rises, the block SHALL stay in IDLE until start.

Verification
REQ-034 MODE0, init_time=64, start, three separated stack_ok pulses -> step_time 32,16,8; level 3; tick period 8 cycles afterwards.
REQ-035 MODE0, MIN_TIME=1, init_time=3, three pulses -> step_time 1,1,1; at_floor=1 after first; level 3; tick every cycle.
REQ-036 MODE1, STEP=4, MIN_TIME=1, init_time=10, three pulses -> step_time 6,2,1; init_time=0 at start -> step_time 1.
REQ-037 stack_ok held high 5 cycles -> level +1 only; stack_miss coincident with edge -> OVER, won=0, level unchanged, tick=0.
REQ-038 MAX_LEVEL=3, three pulses -> OVER, won=1, level 3, tick stops; further pulses ignored; start -> RUN, level 0, won 0.
REQ-039 rst_n low mid-RUN between clock edges -> all outputs 0 without a clock edge; release -> IDLE.
